// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among N requesters.
// Latency: accept at edge t, result captured at t+1, resp_valid high the cycle after t+1.
// Backpressure: at most one grant per two cycles. Responses cannot be stalled and must be sampled on the pulse.
module alu_arbiter #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_inA,
    input  logic [N*W-1:0] req_inB,
    input  logic [N-1:0]   req_inC,
    input  logic [N*3-1:0] req_opc,
    output logic [N-1:0]   req_ready,
    output logic [N-1:0]   resp_valid,
    output logic [W-1:0]   resp_outW,
    output logic           resp_zer,
    output logic           resp_neg,
    output logic [W-1:0]   alu_inA,
    output logic [W-1:0]   alu_inB,
    output logic           alu_inC,
    output logic [2:0]     alu_opc,
    input  logic [W-1:0]   alu_outW,
    input  logic           alu_zer,
    input  logic           alu_neg
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, EXEC} state_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [2:0]   opc;
    } op_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, cur_q;
    logic [PW-1:0] grant_idx;
    logic          grant_found;
    logic [PW:0]   scan;
    logic          accept;
    logic [PW-1:0] ptr_next;
    op_t           sel_op, op_q;

    // Scan requesters starting at ptr, wrapping mod N; first valid wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = '0;
        for (int k = 0; k < N; k++) begin
            scan = {1'b0, ptr_q} + (PW+1)'(k);
            if (scan >= (PW+1)'(N))
                scan = scan - (PW+1)'(N);
            if (!grant_found && req_valid[scan[PW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan[PW-1:0];
            end
        end
    end

    // Reset suppresses the grant so nothing is accepted in the reset cycle.
    assign accept   = (state_q == IDLE) && grant_found && !rst;
    assign ptr_next = (grant_idx == PW'(N-1)) ? '0 : grant_idx + 1'b1;

    // Mux the granted requester's operands toward the operand registers.
    always_comb begin
        sel_op.a   = req_inA[int'(grant_idx)*W +: W];
        sel_op.b   = req_inB[int'(grant_idx)*W +: W];
        sel_op.c   = req_inC[grant_idx];
        sel_op.opc = req_opc[int'(grant_idx)*3 +: 3];
    end

    // Next-state and one-hot grant: IDLE accepts, EXEC always returns to IDLE.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d              = EXEC;
                    req_ready[grant_idx] = 1'b1;
                end
            end
            EXEC:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Operand registers, owner index and round-robin pointer update on accept only.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= '0;
            cur_q <= '0;
            ptr_q <= '0;
        end else if (accept) begin
            op_q  <= sel_op;
            cur_q <= grant_idx;
            ptr_q <= ptr_next;
        end
    end

    assign alu_inA = op_q.a;
    assign alu_inB = op_q.b;
    assign alu_inC = op_q.c;
    assign alu_opc = op_q.opc;

    // Capture the ALU output after its full-cycle evaluation and pulse the owner's resp_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= '0;
            resp_outW  <= '0;
            resp_zer   <= 1'b0;
            resp_neg   <= 1'b0;
        end else begin
            resp_valid <= '0;
            if (state_q == EXEC) begin
                resp_valid[cur_q] <= 1'b1;
                resp_outW         <= alu_outW;
                resp_zer          <= alu_zer;
                resp_neg          <= alu_neg;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a reference ALU and a response scoreboard.
// Latency: expects resp_valid two edges after each accept.
// Backpressure: requesters hold valid and operands until granted.
module tb_alu_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_inA;
    logic [N*W-1:0] req_inB;
    logic [N-1:0]   req_inC;
    logic [N*3-1:0] req_opc;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   resp_valid;
    logic [W-1:0]   resp_outW;
    logic           resp_zer;
    logic           resp_neg;
    logic [W-1:0]   alu_inA;
    logic [W-1:0]   alu_inB;
    logic           alu_inC;
    logic [2:0]     alu_opc;
    logic [W-1:0]   alu_outW;
    logic           alu_zer;
    logic           alu_neg;

    alu_arbiter #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_inA(req_inA), .req_inB(req_inB),
        .req_inC(req_inC), .req_opc(req_opc), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_outW(resp_outW),
        .resp_zer(resp_zer), .resp_neg(resp_neg),
        .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_inC(alu_inC), .alu_opc(alu_opc),
        .alu_outW(alu_outW), .alu_zer(alu_zer), .alu_neg(alu_neg)
    );

    always #5 clk = ~clk;

    // Reference ALU: 0 add+carry, 1 sub, 2 and, 3 or, 4 xor, 5 not A, 6 pass A, 7 pass B.
    always_comb begin
        alu_outW = '0;
        case (alu_opc)
            3'd0: alu_outW = alu_inA + alu_inB + 16'(alu_inC);
            3'd1: alu_outW = alu_inA - alu_inB;
            3'd2: alu_outW = alu_inA & alu_inB;
            3'd3: alu_outW = alu_inA | alu_inB;
            3'd4: alu_outW = alu_inA ^ alu_inB;
            3'd5: alu_outW = ~alu_inA;
            3'd6: alu_outW = alu_inA;
            default: alu_outW = alu_inB;
        endcase
    end
    assign alu_zer = (alu_outW == '0);
    assign alu_neg = alu_outW[W-1];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [2:0]  opc;
    } vec_t;

    typedef struct {
        logic [3:0]  v;
        logic [15:0] w;
        logic        z;
        logic        n;
    } rsp_t;

    vec_t pend [N][$];
    rsp_t sb[$];
    int   exp_grant[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Queue one operation for requester r with its hand-computed result; call in expected grant order.
    task automatic add(input int r, input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic [2:0] opc, input logic [15:0] w, input logic z, input logic n);
        vec_t v;
        rsp_t e;
        v.a = a; v.b = b; v.c = c; v.opc = opc;
        pend[r].push_back(v);
        exp_grant.push_back(r);
        e.v = '0;
        e.v[r] = 1'b1;
        e.w = w; e.z = z; e.n = n;
        sb.push_back(e);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (pend[i].size() != 0) begin
                req_valid[i]         = 1'b1;
                req_inA[i*W +: W]    = pend[i][0].a;
                req_inB[i*W +: W]    = pend[i][0].b;
                req_inC[i]           = pend[i][0].c;
                req_opc[i*3 +: 3]    = pend[i][0].opc;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    function automatic bit busy();
        bit b;
        b = (sb.size() != 0);
        for (int i = 0; i < N; i++)
            if (pend[i].size() != 0) b = 1'b1;
        return b;
    endfunction

    function automatic int idx_of(input logic [N-1:0] m);
        for (int i = 0; i < N; i++)
            if (m[i]) return i;
        return 0;
    endfunction

    // Drive queued requests until everything is granted and answered, checking grants, operands and latency.
    task automatic run(input bit spacing, input int max_cyc);
        int         cyc = 0;
        int         prev = -1;
        int         due = -1;
        logic [3:0] due_v = '0;
        logic [3:0] acc;
        int         g = 0;
        bit         chk_alu = 1'b0;
        vec_t       lo;
        drive();
        while (busy() && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (chk_alu) begin
                check("alu_inA", alu_inA, lo.a);
                check("alu_inB", alu_inB, lo.b);
                check("alu_inC", alu_inC, lo.c);
                check("alu_opc", alu_opc, lo.opc);
                chk_alu = 1'b0;
            end
            if (cyc == due)
                check("resp_latency", resp_valid, due_v);
            if (req_ready != '0) begin
                check("ready_not_valid", req_ready & ~req_valid, 0);
                check("ready_onehot", $countones(req_ready), 1);
            end
            acc = req_ready & req_valid;
            if (acc != '0) begin
                g = idx_of(acc);
                if (exp_grant.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL grant_unexpected: got grant %0d, required none", g);
                end else begin
                    check("grant_idx", g, exp_grant.pop_front());
                end
                if (spacing && prev >= 0)
                    check("grant_spacing", cyc - prev, 2);
                prev  = cyc;
                due   = cyc + 2;
                due_v = acc;
            end
            @(posedge clk);
            #1;
            if (acc != '0) begin
                lo = pend[g].pop_front();
                chk_alu = 1'b1;
                drive();
            end
        end
        if (busy()) begin
            n_cmp++; n_bad++;
            $display("FAIL run_timeout: got %0d outstanding responses after %0d cycles, required 0", sb.size(), cyc);
            sb.delete();
            exp_grant.delete();
            for (int i = 0; i < N; i++) pend[i].delete();
            drive();
        end
    endtask

    // Monitor: every response pulse pops and compares against the scoreboard.
    always @(negedge clk) begin
        rsp_t e;
        if (resp_valid != '0) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL resp_unexpected: got resp_valid %b, required no response", resp_valid);
            end else begin
                e = sb.pop_front();
                check("resp_valid", resp_valid, e.v);
                check("resp_outW", resp_outW, e.w);
                check("resp_zer", resp_zer, e.z);
                check("resp_neg", resp_neg, e.n);
            end
        end
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_inA = '0; req_inB = '0; req_inC = '0; req_opc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_outW", resp_outW, 0);
        check("rst_resp_flags", {resp_zer, resp_neg}, 0);
        check("rst_alu_ops", {alu_inA, alu_inB}, 0);
        check("rst_alu_ctl", {alu_inC, alu_opc}, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Single request from requester 0.
        add(0, 16'h1234, 16'h0F0F, 1'b1, 3'd2, 16'h0204, 1'b0, 1'b0);
        run(1'b0, 40);

        // All four requesting continuously from reset: grants 0,1,2,3,0.
        @(posedge clk); #1 rst = 1'b1;
        add(0, 16'h0001, 16'h0002, 1'b0, 3'd0, 16'h0003, 1'b0, 1'b0);
        add(1, 16'hFFFF, 16'h0001, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
        add(2, 16'h5555, 16'hAAAA, 1'b0, 3'd3, 16'hFFFF, 1'b0, 1'b1);
        add(3, 16'h1234, 16'h1234, 1'b0, 3'd4, 16'h0000, 1'b1, 1'b0);
        add(0, 16'h8000, 16'h0001, 1'b0, 3'd1, 16'h7FFF, 1'b0, 1'b0);
        drive();
        @(negedge clk);
        check("ready_in_reset", req_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        run(1'b1, 60);

        // Rotation: after 2 is granted, 1 and 3 both valid -> 3 then 1.
        add(2, 16'h00FF, 16'h0000, 1'b0, 3'd5, 16'hFF00, 1'b0, 1'b1);
        run(1'b0, 40);
        add(3, 16'h0BAD, 16'h0000, 1'b0, 3'd6, 16'h0BAD, 1'b0, 1'b0);
        add(1, 16'h0000, 16'hCAFE, 1'b0, 3'd7, 16'hCAFE, 1'b0, 1'b1);
        run(1'b0, 40);

        // Lone requester 3 streaming five operations.
        add(3, 16'h0010, 16'h0020, 1'b1, 3'd0, 16'h0031, 1'b0, 1'b0);
        add(3, 16'h0100, 16'h0001, 1'b0, 3'd1, 16'h00FF, 1'b0, 1'b0);
        add(3, 16'hF0F0, 16'h3C3C, 1'b0, 3'd2, 16'h3030, 1'b0, 1'b0);
        add(3, 16'h1000, 16'h0001, 1'b0, 3'd3, 16'h1001, 1'b0, 1'b0);
        add(3, 16'hFFFF, 16'h00FF, 1'b0, 3'd4, 16'hFF00, 1'b0, 1'b1);
        run(1'b1, 60);

        // Reset during EXEC discards the in-flight operation.
        req_valid = 4'b0010;
        req_inA[W +: W] = 16'h1111;
        req_inB[W +: W] = 16'h2222;
        req_inC[1] = 1'b0;
        req_opc[3 +: 3] = 3'd0;
        @(negedge clk);
        check("midrst_grant", req_ready, 4'b0010);
        @(posedge clk); #1 req_valid = '0; rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", req_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_resp_valid", resp_valid, 0);
        check("midrst_alu_ops", {alu_inA, alu_inB}, 0);
        check("midrst_alu_ctl", {alu_inC, alu_opc}, 0);
        check("midrst_ptr", dut.ptr_q, 0);
        @(negedge clk);
        check("midrst_resp_valid2", resp_valid, 0);
        @(posedge clk); #1;
        add(3, 16'h0003, 16'h0004, 1'b0, 3'd0, 16'h0007, 1'b0, 1'b0);
        run(1'b0, 40);

        // Flag pass-through and hold between pulses.
        add(0, 16'h00F0, 16'h0F00, 1'b0, 3'd2, 16'h0000, 1'b1, 1'b0);
        run(1'b0, 40);
        repeat (3) @(negedge clk);
        check("hold_zero_flags", {resp_zer, resp_neg}, 2'b10);
        check("hold_zero_outW", resp_outW, 16'h0000);
        @(posedge clk); #1;
        add(1, 16'h7FFF, 16'h0000, 1'b1, 3'd0, 16'h8000, 1'b0, 1'b1);
        run(1'b0, 40);
        repeat (3) @(negedge clk);
        check("hold_neg_flags", {resp_zer, resp_neg}, 2'b01);
        check("hold_neg_outW", resp_outW, 16'h8000);

        check("sb_drained", sb.size(), 0);
        check("grants_drained", exp_grant.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
